wb_master_arbiter: RTL and testbench
====================================

# wb_master_arbiter

Round-robin arbiter that shares one Wishbone classic bus between several masters in the okClk domain. Typical use: the OpalKelly pipe bridge plus autonomous sequencers, such as an SFP+ I2C init engine or a statistics poller, all feeding the single slave-side crossbar. Ownership is locked for the whole `cyc` of the winning master. A watchdog aborts transfers that never receive an ack, so a dead slave cannot hang the host.

## Interface
Parameters:
- `MASTERS`, default 2: number of requesting masters, 2..8.
- `ADR_WIDTH`, default 24: Wishbone address width.
- `TIMEOUT`, default 1024: cycles from `s_stb_o` without `s_ack_i` until abort, ≥4.

Ports:
- `wb_clk` in 1: single clock (okClk).
- `wb_rst` in 1: reset, synchronous, active-high.
- `m_cyc_i` in MASTERS: per-master cycle.
- `m_stb_i` in MASTERS: per-master strobe.
- `m_we_i` in MASTERS: per-master write enable.
- `m_adr_i` in MASTERS*ADR_WIDTH: per-master address; master k occupies slice k.
- `m_dat_i` in MASTERS*32: per-master write data; master k occupies slice k.
- `m_dat_o` out 32: read data, broadcast to all masters.
- `m_ack_o` out MASTERS: per-master ack.
- `m_err_o` out MASTERS: per-master timeout error, one-cycle pulse.
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1: to the crossbar.
- `s_adr_o` out ADR_WIDTH: to the crossbar.
- `s_dat_o` out 32: write data to the crossbar.
- `s_dat_i` in 32: read data from the crossbar.
- `s_ack_i` in 1: ack from the crossbar.
- `grant_o` out MASTERS: one-hot current owner; zero when idle.
- `timeout_cnt_o` out 16: saturating count of aborted transfers.

## Operation
FSM states are IDLE, OWN and ABORT.

IDLE:
- If any `m_cyc_i` bit is high, register a one-hot grant for the first requester at or after `last+1`, searching modulo MASTERS, then go to OWN.
- `last` is the index granted most recently. Reset value is MASTERS-1, so master 0 wins first.

OWN:
- `s_cyc_o`, `s_stb_o`, `s_we_o`, `s_adr_o` and `s_dat_o` are a combinational mux of the granted master's inputs.
- `m_ack_o[g] = s_ack_i`. `m_dat_o = s_dat_i` in all states.
- When the owner drops `m_cyc_i`, clear the grant, update `last`, go to IDLE.
- Stb/ack of other masters are ignored. Their `m_ack_o` and `m_err_o` stay 0.

Watchdog:
- Counter clears whenever `s_stb_o` is low or `s_ack_i` is high.
- Otherwise it increments.
- At TIMEOUT-1, go to ABORT.

ABORT (exactly one cycle):
- `s_cyc_o` and `s_stb_o` are 0, `m_err_o[g]=1`.
- `timeout_cnt_o` increments, saturating at 0xFFFF.
- `s_ack_i` in this cycle is dropped, not forwarded.
- Next state is OWN; the owner retains the grant and may retry or release.

Simultaneous events:
- Owner drops cyc in the same cycle as another master raises cyc: release first; the new grant is made in the following IDLE cycle.
- `s_ack_i` on the same cycle the counter hits TIMEOUT-1: the ack wins and there is no abort.

## Timing
- Reset values: state IDLE, `grant_o=0`, `last=MASTERS-1`, watchdog 0, `timeout_cnt_o=0`. Consequently all `s_*_o`, `m_ack_o` and `m_err_o` are 0.
- Reset mid-transfer: from the edge where `wb_rst` is sampled high, `s_cyc_o=0` and no ack is forwarded.
- Grant latency: cyc in IDLE at cycle n → `s_cyc_o` high at n+1.
- Ack path: combinational, zero added latency.
- Handover gap: one IDLE cycle between consecutive owners.
- Abort: `m_err_o` rises TIMEOUT cycles after `s_stb_o` first goes high without an ack.
- Registered elements: grant, last, state, watchdog, counter. All slave-side signals are combinational from these plus master inputs.

## Structure
- Package `wb_arb_pkg` holds:
  - state enum `arb_state_t` {IDLE, OWN, ABORT};
  - `localparam DAT_WIDTH = 32`;
  - `TIMEOUT_CNT_WIDTH = 16`.
- Sub-module `rr_pick`: combinational one-hot round-robin selector.
  - Parameter N.
  - Inputs `req[N]`, `last[$clog2(N)]`.
  - Outputs `gnt[N]`, `idx`, `any`.

## Test plan
- **Single master:** master 0 writes addr 0x000015, data 0xA5A5A5A5; the slave acks 2 cycles after stb.
  - `s_cyc_o` rises 1 cycle after `m_cyc_i[0]`.
  - `s_adr_o`/`s_dat_o` match; `m_ack_o[0]` pulses once.
  - `grant_o` returns to 0 one cycle after cyc drops.
- **Contention from reset:** both masters raise cyc in the same cycle.
  - Master 0 is served first, then master 1 after a 1-cycle gap.
  - A third back-to-back request from both is granted to master 0 again; strict alternation is checked over 10 rounds.
- **Ownership lock:** master 0 holds cyc across 3 reads (return values 0x1, 0x2, 0x3) while master 1 requests.
  - `m_ack_o[1]` stays 0 throughout; master 1 is granted only after master 0 releases.
- **Timeout:** TIMEOUT=16, slave never acks.
  - `m_err_o[0]` pulses exactly 16 cycles after stb, with `s_cyc_o` low that cycle; `timeout_cnt_o=1`.
  - A retry that is acked completes normally.
- **Ack at the boundary:** ack arrives exactly at watchdog count 15 → no err, `timeout_cnt_o` unchanged.
- **Reset mid-transfer:** `wb_rst` is pulsed during an OWN cycle with stb high.
  - All outputs are 0 on the next cycle.
  - The first grant after reset goes to master 0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types for the Wishbone master arbiter.
// State encoding and bus widths used by the arbiter and its helpers.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        ABORT
    } arb_state_t;

    localparam int DAT_WIDTH = 32;
    localparam int TIMEOUT_CNT_WIDTH = 16;

endpackage

// File: rtl/wb_master_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or after last+1.
// Produces a one-hot grant, its index and an any-request flag.
module rr_pick #(
    parameter int N  = 2,
    parameter int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [LW-1:0] idx,
    output logic          any
);

    always_comb begin : pick
        int c;
        c   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int off = 1; off <= N; off++) begin
            c = (int'(last) + off) % N;
            if (!any && req[c]) begin
                any    = 1'b1;
                gnt[c] = 1'b1;
                idx    = LW'(c);
            end
        end
    end

endmodule

// File: rtl/wb_master_arbiter.sv
// Round-robin Wishbone classic arbiter, ownership locked per cyc,
// with a no-ack watchdog that aborts stalled transfers.
module wb_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int MASTERS   = 2,
    parameter int ADR_WIDTH = 24,
    parameter int TIMEOUT   = 1024
) (
    input  logic                           wb_clk,
    input  logic                           wb_rst,
    input  logic [MASTERS-1:0]             m_cyc_i,
    input  logic [MASTERS-1:0]             m_stb_i,
    input  logic [MASTERS-1:0]             m_we_i,
    input  logic [MASTERS*ADR_WIDTH-1:0]   m_adr_i,
    input  logic [MASTERS*DAT_WIDTH-1:0]   m_dat_i,
    output logic [DAT_WIDTH-1:0]           m_dat_o,
    output logic [MASTERS-1:0]             m_ack_o,
    output logic [MASTERS-1:0]             m_err_o,
    output logic                           s_cyc_o,
    output logic                           s_stb_o,
    output logic                           s_we_o,
    output logic [ADR_WIDTH-1:0]           s_adr_o,
    output logic [DAT_WIDTH-1:0]           s_dat_o,
    input  logic [DAT_WIDTH-1:0]           s_dat_i,
    input  logic                           s_ack_i,
    output logic [MASTERS-1:0]             grant_o,
    output logic [TIMEOUT_CNT_WIDTH-1:0]   timeout_cnt_o
);

    localparam int LW  = $clog2(MASTERS);
    localparam int WDW = $clog2(TIMEOUT);

    arb_state_t         state;
    logic [LW-1:0]      last;
    logic [WDW-1:0]     wd;
    logic [MASTERS-1:0] pick_gnt;
    logic [LW-1:0]      pick_idx;
    logic               pick_any;
    logic               own;
    logic               wd_hit;

    rr_pick #(
        .N  (MASTERS),
        .LW (LW)
    ) u_pick (
        .req  (m_cyc_i),
        .last (last),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // last is loaded at grant time, so it also names the current owner
    assign own     = (state == OWN);
    assign s_cyc_o = own & m_cyc_i[last];
    assign s_stb_o = own & m_stb_i[last];
    assign s_we_o  = own & m_we_i[last];
    assign s_adr_o = own ? m_adr_i[int'(last)*ADR_WIDTH +: ADR_WIDTH] : '0;
    assign s_dat_o = own ? m_dat_i[int'(last)*DAT_WIDTH +: DAT_WIDTH] : '0;
    assign m_dat_o = s_dat_i;

    assign m_ack_o = own ? (grant_o & {MASTERS{s_ack_i}}) : '0;
    assign m_err_o = (state == ABORT) ? grant_o : '0;
    assign wd_hit  = (wd == WDW'(TIMEOUT - 1));

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state         <= IDLE;
            grant_o       <= '0;
            last          <= LW'(MASTERS - 1);
            wd            <= '0;
            timeout_cnt_o <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    wd <= '0;
                    if (pick_any) begin
                        grant_o <= pick_gnt;
                        last    <= pick_idx;
                        state   <= OWN;
                    end
                end
                OWN: begin
                    if (!m_cyc_i[last]) begin
                        grant_o <= '0;
                        wd      <= '0;
                        state   <= IDLE;
                    end else if (!s_stb_o || s_ack_i) begin
                        wd <= '0;
                    end else if (wd_hit) begin
                        wd    <= '0;
                        state <= ABORT;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                ABORT: begin
                    wd    <= '0;
                    state <= OWN;
                    if (timeout_cnt_o != '1)
                        timeout_cnt_o <= timeout_cnt_o + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter: 2 masters, TIMEOUT=16.
// Expected values are hand-derived cycle by cycle.
module tb_wb_master_arbiter;

    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b1;
    logic [1:0]  m_cyc = '0;
    logic [1:0]  m_stb = '0;
    logic [1:0]  m_we = '0;
    logic [47:0] m_adr = '0;
    logic [63:0] m_dat = '0;
    logic [31:0] m_dat_o;
    logic [1:0]  m_ack_o;
    logic [1:0]  m_err_o;
    logic        s_cyc_o;
    logic        s_stb_o;
    logic        s_we_o;
    logic [23:0] s_adr_o;
    logic [31:0] s_dat_o;
    logic [31:0] s_dat_i = '0;
    logic        s_ack_i = 1'b0;
    logic [1:0]  grant_o;
    logic [15:0] timeout_cnt_o;

    int total = 0;
    int bad = 0;
    logic [1:0] exp_g;

    always #5 wb_clk = ~wb_clk;

    wb_master_arbiter #(
        .MASTERS   (2),
        .ADR_WIDTH (24),
        .TIMEOUT   (16)
    ) dut (
        .wb_clk        (wb_clk),
        .wb_rst        (wb_rst),
        .m_cyc_i       (m_cyc),
        .m_stb_i       (m_stb),
        .m_we_i        (m_we),
        .m_adr_i       (m_adr),
        .m_dat_i       (m_dat),
        .m_dat_o       (m_dat_o),
        .m_ack_o       (m_ack_o),
        .m_err_o       (m_err_o),
        .s_cyc_o       (s_cyc_o),
        .s_stb_o       (s_stb_o),
        .s_we_o        (s_we_o),
        .s_adr_o       (s_adr_o),
        .s_dat_o       (s_dat_o),
        .s_dat_i       (s_dat_i),
        .s_ack_i       (s_ack_i),
        .grant_o       (grant_o),
        .timeout_cnt_o (timeout_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic rst_bus();
        wb_rst  = 1'b1;
        m_cyc   = '0;
        m_stb   = '0;
        m_we    = '0;
        s_ack_i = 1'b0;
        tick();
        tick();
        wb_rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        // reset state and single master write
        rst_bus();
        #1;
        chk("rst_grant", grant_o, 0);
        chk("rst_scyc", s_cyc_o, 0);
        chk("rst_ack", m_ack_o, 0);
        chk("rst_err", m_err_o, 0);
        chk("rst_tcnt", timeout_cnt_o, 0);
        m_cyc = 2'b01;
        m_stb = 2'b01;
        m_we  = 2'b01;
        m_adr[23:0] = 24'h000015;
        m_dat[31:0] = 32'hA5A5A5A5;
        #1;
        chk("t1_scyc_pre", s_cyc_o, 0);
        tick();
        chk("t1_scyc", s_cyc_o, 1);
        chk("t1_grant", grant_o, 2'b01);
        chk("t1_adr", s_adr_o, 32'h15);
        chk("t1_dat", s_dat_o, 32'hA5A5A5A5);
        chk("t1_we", s_we_o, 1);
        tick();
        chk("t1_noack", m_ack_o, 0);
        tick();
        s_ack_i = 1'b1;
        #1;
        chk("t1_ack", m_ack_o, 2'b01);
        tick();
        s_ack_i = 1'b0;
        m_cyc = '0;
        m_stb = '0;
        m_we  = '0;
        #1;
        chk("t1_ack_end", m_ack_o, 0);
        chk("t1_hold", grant_o, 2'b01);
        tick();
        chk("t1_rel", grant_o, 0);
        chk("t1_rel_cyc", s_cyc_o, 0);

        // contention and strict alternation
        rst_bus();
        exp_g = 2'b01;
        for (int r = 0; r < 10; r++) begin
            m_cyc = 2'b11;
            m_stb = 2'b11;
            #1;
            chk($sformatf("t2_gap%0d", r), grant_o, 0);
            tick();
            chk($sformatf("t2_grant%0d", r), grant_o, exp_g);
            chk($sformatf("t2_cyc%0d", r), s_cyc_o, 1);
            m_cyc = ~exp_g;
            tick();
            exp_g = {exp_g[0], exp_g[1]};
        end
        m_cyc = '0;
        m_stb = '0;
        tick();
        tick();

        // ownership lock across three reads
        rst_bus();
        m_cyc = 2'b11;
        m_stb = 2'b11;
        tick();
        chk("t3_grant0", grant_o, 2'b01);
        for (int i = 1; i <= 3; i++) begin
            s_dat_i = 32'(i);
            s_ack_i = 1'b1;
            #1;
            chk($sformatf("t3_rd%0d", i), m_dat_o, 32'(i));
            chk($sformatf("t3_ack%0d", i), m_ack_o, 2'b01);
            tick();
            s_ack_i = 1'b0;
            #1;
            chk($sformatf("t3_idle%0d", i), m_ack_o, 0);
            tick();
        end
        m_cyc = 2'b10;
        m_stb = 2'b10;
        tick();
        chk("t3_gap", grant_o, 0);
        tick();
        chk("t3_grant1", grant_o, 2'b10);
        m_cyc = '0;
        m_stb = '0;
        tick();
        tick();

        // watchdog abort and acked retry
        rst_bus();
        m_cyc = 2'b01;
        m_stb = 2'b01;
        tick();
        chk("t4_stb", s_stb_o, 1);
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk($sformatf("t4_noerr%0d", k), m_err_o, 0);
        end
        tick();
        s_ack_i = 1'b1;
        #1;
        chk("t4_err", m_err_o, 2'b01);
        chk("t4_abort_cyc", s_cyc_o, 0);
        chk("t4_abort_stb", s_stb_o, 0);
        chk("t4_drop_ack", m_ack_o, 0);
        tick();
        s_ack_i = 1'b0;
        #1;
        chk("t4_tcnt", timeout_cnt_o, 1);
        chk("t4_retry_cyc", s_cyc_o, 1);
        chk("t4_err_end", m_err_o, 0);
        s_ack_i = 1'b1;
        #1;
        chk("t4_retry_ack", m_ack_o, 2'b01);
        tick();
        s_ack_i = 1'b0;
        m_cyc = '0;
        m_stb = '0;
        tick();
        chk("t4_rel", grant_o, 0);
        chk("t4_tcnt2", timeout_cnt_o, 1);

        // ack arriving on watchdog count 15
        m_cyc = 2'b01;
        m_stb = 2'b01;
        tick();
        for (int k = 1; k <= 14; k++) tick();
        tick();
        s_ack_i = 1'b1;
        #1;
        chk("t5_ack", m_ack_o, 2'b01);
        tick();
        s_ack_i = 1'b0;
        #1;
        chk("t5_noerr", m_err_o, 0);
        chk("t5_tcnt", timeout_cnt_o, 1);
        m_cyc = '0;
        m_stb = '0;
        tick();
        tick();

        // reset while owning with stb high
        m_cyc = 2'b01;
        m_stb = 2'b01;
        m_we  = 2'b01;
        tick();
        chk("t6_own", s_cyc_o, 1);
        wb_rst  = 1'b1;
        s_ack_i = 1'b1;
        tick();
        chk("t6_cyc", s_cyc_o, 0);
        chk("t6_stb", s_stb_o, 0);
        chk("t6_we", s_we_o, 0);
        chk("t6_adr", s_adr_o, 0);
        chk("t6_grant", grant_o, 0);
        chk("t6_ack", m_ack_o, 0);
        chk("t6_err", m_err_o, 0);
        chk("t6_tcnt", timeout_cnt_o, 0);
        wb_rst  = 1'b0;
        s_ack_i = 1'b0;
        m_cyc   = 2'b11;
        m_stb   = 2'b11;
        tick();
        chk("t6_first", grant_o, 2'b01);
        m_cyc = '0;
        m_stb = '0;
        m_we  = '0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
